// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and defaults for the pipeline stall/flush
//               sequencer and its helpers.
//               state_e       - sequencer state encoding
//               DRAIN_CYC_DEF - cycles for HLT to reach retirement from ID/EX
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IMISS  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int DRAIN_CYC_DEF = 3;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational load-use hazard compare. Flags when the
//               instruction in ID reads a register that a load in EX is
//               about to write. R0 is hard-wired zero and never hazards.
// Ports       : ex_memread, ex_rd       - load in EX and its destination
//               id_rs/id_rt, id_use_*   - ID sources and their read flags
//               lu_haz                  - load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_AW = 4
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic              lu_haz
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_use_rs && (id_rs == ex_rd);
  assign rt_match = id_use_rt && (id_rt == ex_rd);
  assign lu_haz   = ex_memread && (ex_rd != '0) && (rs_match || rt_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Drives PC, IF/ID, ID/EX and EX/MEM enables and flush/bubble
//               controls for load-use, redirect, I/D-memory stalls and HLT
//               drain. Outputs are combinational (zero-cycle latency).
// Ports       : clk, rst (async, active-low)
//               id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rd
//               id_br_taken, id_halt, imem_stall, dmem_stall
//               pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en
//               halted (sticky until reset)
// Option      : HAZARD_PERF_CNT_EN adds saturating counters lu_stall_cnt,
//               imiss_cnt, dmiss_cnt (CNT_W bits each).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_br_taken,
  input  logic              id_halt,
  input  logic              imem_stall,
  input  logic              dmem_stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  imiss_cnt,
  output logic [CNT_W-1:0]  dmiss_cnt,
`endif
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_en,
  output logic              halted
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);

  state_e         state_q, state_d;
  logic           redir_pend_q, redir_pend_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           lu_haz;

  // Decoded controls before reset gating; flops never see rst as data.
  logic dec_pc_en, dec_ifid_en, dec_ifid_flush;
  logic dec_idex_en, dec_idex_bubble, dec_exmem_en;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .lu_haz     (lu_haz)
  );

  always_comb begin
    dec_pc_en       = 1'b0;
    dec_ifid_en     = 1'b0;
    dec_ifid_flush  = 1'b0;
    dec_idex_en     = 1'b0;
    dec_idex_bubble = 1'b0;
    dec_exmem_en    = 1'b0;
    state_d         = state_q;
    redir_pend_d    = redir_pend_q;
    drain_cnt_d     = drain_cnt_q;

    if (!dmem_stall) begin
      case (state_q)
        HALTED: ;
        DRAIN: begin
          // Bubbles behind the HLT while it walks to WB.
          dec_ifid_en     = 1'b1;
          dec_ifid_flush  = 1'b1;
          dec_idex_en     = 1'b1;
          dec_idex_bubble = 1'b1;
          dec_exmem_en    = 1'b1;
          if (drain_cnt_q == '0) state_d = HALTED;
          else                   drain_cnt_d = drain_cnt_q - 1'b1;
        end
        default: begin  // RUN / IMISS
          if (lu_haz) begin
            // One-cycle bubble; branch/halt re-evaluate next cycle.
            dec_idex_en     = 1'b1;
            dec_idex_bubble = 1'b1;
            dec_exmem_en    = 1'b1;
          end else if ((state_q == IMISS) && imem_stall) begin
            // Fetch still outstanding: hold PC, NOP into IF/ID.
            dec_ifid_en    = 1'b1;
            dec_ifid_flush = 1'b1;
            dec_idex_en    = 1'b1;
            dec_exmem_en   = 1'b1;
          end else begin
            if (state_q == IMISS) redir_pend_d = 1'b0;
            state_d = RUN;
            if (id_halt) begin
              dec_ifid_en    = 1'b1;
              dec_ifid_flush = 1'b1;
              dec_idex_en    = 1'b1;
              dec_exmem_en   = 1'b1;
              state_d        = DRAIN;
              drain_cnt_d    = DRAIN_LOAD;
            end else if (id_br_taken) begin
              // Target loads into PC; the wrong-path fetch is killed.
              dec_pc_en      = 1'b1;
              dec_ifid_en    = 1'b1;
              dec_ifid_flush = 1'b1;
              dec_idex_en    = 1'b1;
              dec_exmem_en   = 1'b1;
              if (imem_stall) begin
                redir_pend_d = 1'b1;
                state_d      = IMISS;
              end
            end else if (imem_stall) begin
              dec_ifid_en    = 1'b1;
              dec_ifid_flush = 1'b1;
              dec_idex_en    = 1'b1;
              dec_exmem_en   = 1'b1;
              state_d        = IMISS;
            end else begin
              dec_pc_en    = 1'b1;
              dec_ifid_en  = 1'b1;
              dec_idex_en  = 1'b1;
              dec_exmem_en = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  // All pipeline writes are suppressed while reset is held.
  assign pc_en       = rst && dec_pc_en;
  assign ifid_en     = rst && dec_ifid_en;
  assign ifid_flush  = rst && dec_ifid_flush;
  assign idex_en     = rst && dec_idex_en;
  assign idex_bubble = rst && dec_idex_bubble;
  assign exmem_en    = rst && dec_exmem_en;
  assign halted      = (state_q == HALTED);

  // A pending redirect only exists while the refetch is outstanding.
  a_redir_in_imiss: assert property (@(posedge clk) disable iff (!rst)
    redir_pend_q |-> (state_q == IMISS));

`ifdef HAZARD_PERF_CNT_EN
  logic             lu_act, imiss_act, dmiss_act;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] imiss_cnt_q, imiss_cnt_d;
  logic [CNT_W-1:0] dmiss_cnt_q, dmiss_cnt_d;

  // Stall conditions as actually applied after priority.
  assign lu_act    = !dmem_stall && lu_haz &&
                     ((state_q == RUN) || (state_q == IMISS));
  assign imiss_act = !dmem_stall && !lu_haz && imem_stall &&
                     ((state_q == IMISS) ||
                      ((state_q == RUN) && !id_halt && !id_br_taken));
  assign dmiss_act = dmem_stall && (state_q != HALTED);

  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    imiss_cnt_d = imiss_cnt_q;
    dmiss_cnt_d = dmiss_cnt_q;
    if (state_q != HALTED) begin
      if (lu_act    && !(&lu_cnt_q))    lu_cnt_d    = lu_cnt_q + 1'b1;
      if (imiss_act && !(&imiss_cnt_q)) imiss_cnt_d = imiss_cnt_q + 1'b1;
      if (dmiss_act && !(&dmiss_cnt_q)) dmiss_cnt_d = dmiss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q    <= '0;
      imiss_cnt_q <= '0;
      dmiss_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      imiss_cnt_q <= imiss_cnt_d;
      dmiss_cnt_q <= dmiss_cnt_d;
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign imiss_cnt    = imiss_cnt_q;
  assign dmiss_cnt    = dmiss_cnt_q;
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl. The driver applies
//               one directed vector per cycle and queues its hand-computed
//               output word; the monitor pops and compares on the falling
//               edge. Word = {pc_en, ifid_en, ifid_flush, idex_en,
//               idex_bubble, exmem_en, halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] E_ZERO = 7'b000_0000;
  localparam logic [6:0] E_ALL  = 7'b110_1010;
  localparam logic [6:0] E_LU   = 7'b000_1110;
  localparam logic [6:0] E_BRF  = 7'b111_1010;
  localparam logic [6:0] E_MISS = 7'b011_1010;  // also HLT acceptance
  localparam logic [6:0] E_DRN  = 7'b011_1110;
  localparam logic [6:0] E_HLTD = 7'b000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_memread;
  logic       id_br_taken, id_halt, imem_stall, dmem_stall;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_stall_cnt, imiss_cnt, dmiss_cnt;
`endif

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(4), .DRAIN_CYC(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_br_taken (id_br_taken),
    .id_halt     (id_halt),
    .imem_stall  (imem_stall),
    .dmem_stall  (dmem_stall),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt),
    .imiss_cnt   (imiss_cnt),
    .dmiss_cnt   (dmiss_cnt),
`endif
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_bubble (idex_bubble),
    .exmem_en    (exmem_en),
    .halted      (halted)
  );

  // Monitor: compares whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, halted};
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (pc,ifid,flush,idex,bub,exmem,halt)",
                 e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string nm, input logic [6:0] e);
    exp_t t;
    t.name = nm;
    t.exp  = e;
    exp_q.push_back(t);
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
    id_br_taken = 1'b0; id_halt = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  // One cycle of stimulus: applied just after the rising edge.
  task automatic vec(input string nm, input logic mr, input logic [3:0] rd,
                     input logic [3:0] rs, input logic urs,
                     input logic [3:0] rt, input logic urt,
                     input logic br, input logic hlt, input logic ims,
                     input logic dms, input logic [6:0] e);
    @(posedge clk);
    #1;
    ex_memread = mr; ex_rd = rd; id_rs = rs; id_use_rs = urs;
    id_rt = rt; id_use_rt = urt; id_br_taken = br; id_halt = hlt;
    imem_stall = ims; dmem_stall = dms;
    push(nm, e);
  endtask

  initial begin
    int budget;
    clr();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 push("reset", E_ZERO);
    #10 rst = 1'b1;

    //   name             mr rd    rs    urs rt    urt br hlt ims dms exp
    vec("normal",         0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("lu_rs",          1, 4'd3, 4'd3, 1, 4'd0, 0,  0, 0,  0,  0, E_LU);
    vec("lu_after",       0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("lu_rt",          1, 4'd5, 4'd0, 0, 4'd5, 1,  0, 0,  0,  0, E_LU);
    vec("lu_no_use",      1, 4'd5, 4'd5, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("load_r0",        1, 4'd0, 4'd0, 1, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("lu_and_dmem",    1, 4'd3, 4'd3, 1, 4'd0, 0,  0, 0,  0,  1, E_ZERO);
    vec("lu_after_dmem",  1, 4'd3, 4'd3, 1, 4'd0, 0,  0, 0,  0,  0, E_LU);
    vec("post_lu",        0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("br_hit",         0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  0,  0, E_BRF);
    vec("br_miss_c0",     0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  1,  0, E_BRF);
    vec("br_miss_c1",     0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  1,  0, E_MISS);
    vec("br_miss_c2",     0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  1,  0, E_MISS);
    vec("br_miss_c3",     0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  1,  0, E_MISS);
    vec("br_miss_end",    0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("imiss_only",     0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  1,  0, E_MISS);
    vec("imiss_end",      0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("lu_over_br",     1, 4'd3, 4'd3, 1, 4'd0, 0,  1, 0,  0,  0, E_LU);
    vec("halt_accept",    0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 1,  0,  0, E_MISS);
    vec("drain_0",        0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_DRN);
    vec("drain_dmem_0",   0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  1, E_ZERO);
    vec("drain_dmem_1",   0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  1, E_ZERO);
    vec("drain_1",        0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_DRN);
    vec("drain_2",        0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_DRN);
    vec("halted",         0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_HLTD);
    vec("halted_sticky",  0, 4'd0, 4'd0, 0, 4'd0, 0,  1, 0,  0,  0, E_HLTD);

    // Leave HALTED, start a second HLT and reset in the middle of DRAIN.
    @(posedge clk); #1; clr(); rst = 1'b0;
    push("rst_from_halted", E_ZERO);
    @(negedge clk); #2 rst = 1'b1;
    vec("halt_accept_2",  0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 1,  0,  0, E_MISS);
    vec("drain_b0",       0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_DRN);
    @(posedge clk); #3 rst = 1'b0;   // no clock edge before the check
    push("rst_mid_drain", E_ZERO);
    @(negedge clk); #2 rst = 1'b1;
    vec("post_rst_run",   0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);
    vec("post_rst_imiss", 0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  1,  0, E_MISS);
    vec("post_rst_end",   0, 4'd0, 4'd0, 0, 4'd0, 0,  0, 0,  0,  0, E_ALL);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_queue: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
